// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready load/store
// request channel and a valid/ready response channel.
// Each access waits LATENCY cycles and then takes effect. Byte, halfword
// and word accesses follow the RV32I funct3 size/sign codes.
// Optional build macro MEM_RESPONDER_MISALIGN_CHK_EN:
//   defined   -> misaligned halfword/word accesses fault (resp_err = 1, no write)
//   undefined -> misaligned accesses are force-aligned and resp_err stays 0
// Storage is not cleared by rst.

module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic [31:0]         mem_q [DEPTH_WORDS];

  logic [ADDR_W-1:0]   word_idx_s;
  logic [31:0]         mem_word_s;
  logic                is_byte_s, is_half_s, is_signed_s;
  logic                misalign_s;
  logic [31:0]         shifted_s;
  logic [15:0]         half_s;
  logic [31:0]         load_data_s;
  logic [31:0]         st_mask_s, st_data_s, st_word_s;
  logic                access_s, mem_we_s;
  logic                unused_addr_s;

  // Address bits above the word index are ignored (wrap-around).
  assign unused_addr_s = ^req_addr[31:ADDR_W+2];

  assign word_idx_s = addr_q[ADDR_W+1:2];
  assign mem_word_s = mem_q[word_idx_s];
  assign access_s   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_we_s   = access_s && wr_q && !misalign_s && !rst;

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Decode access size/sign and alignment fault from the latched request.
  always_comb begin
    is_byte_s   = 1'b0;
    is_half_s   = 1'b0;
    is_signed_s = 1'b0;
    case (f3_q)
      3'b000: begin
        is_byte_s   = 1'b1;
        is_signed_s = !wr_q;
      end
      3'b001: begin
        is_half_s   = 1'b1;
        is_signed_s = !wr_q;
      end
      3'b100:  is_byte_s = !wr_q;   // LBU; a store with this code is a word
      3'b101:  is_half_s = !wr_q;   // LHU; a store with this code is a word
      default: is_byte_s = 1'b0;    // 010 and unlisted codes: word access
    endcase
`ifdef MEM_RESPONDER_MISALIGN_CHK_EN
    if (is_byte_s) begin
      misalign_s = 1'b0;
    end else if (is_half_s) begin
      misalign_s = addr_q[0];
    end else begin
      misalign_s = (addr_q[1:0] != 2'b00);
    end
`else
    misalign_s = 1'b0;
`endif
  end

  // Extract and extend load data; merge store data into the addressed lanes.
  always_comb begin
    shifted_s = mem_word_s >> {addr_q[1:0], 3'b000};
    half_s    = addr_q[1] ? mem_word_s[31:16] : mem_word_s[15:0];
    if (is_byte_s) begin
      load_data_s = is_signed_s ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                                : {24'h00_0000, shifted_s[7:0]};
      st_mask_s   = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      st_data_s   = {4{wdata_q[7:0]}};
    end else if (is_half_s) begin
      load_data_s = is_signed_s ? {{16{half_s[15]}}, half_s}
                                : {16'h0000, half_s};
      st_mask_s   = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      st_data_s   = {2{wdata_q[15:0]}};
    end else begin
      load_data_s = mem_word_s;
      st_mask_s   = 32'hFFFF_FFFF;
      st_data_s   = wdata_q;
    end
    st_word_s = (mem_word_s & ~st_mask_s) | (st_data_s & st_mask_s);
  end

  // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = misalign_s;
          resp_rdata_d = (wr_q || misalign_s) ? 32'h0000_0000 : load_data_s;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; rst wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      f3_q         <= 3'b000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f3_q         <= f3_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage write on the edge that leaves WAIT; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[word_idx_s] <= st_word_s;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed load/store sequence against mem_responder.
// Expected responses are queued at issue time and checked by a monitor
// whenever a response handshake is presented.

module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0000_0000;
  logic [31:0] req_wdata = 32'h0000_0000;
  logic [2:0]  req_funct3 = 3'b000;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  mem_responder #(
    .DEPTH_WORDS(1024),
    .ADDR_W(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per presented response handshake.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e[31:0]);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
        end
      end
    end
  end

  // Issue one request; stall>0 holds resp_ready low for that many cycles of RESP.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] exp_rd,
                       input logic exp_err, input int stall);
    int lat;
    int n;
    @(negedge clk);
    resp_ready = (stall == 0);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({exp_err, exp_rd});
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Keep req_valid high with altered fields while busy: must be ignored.
    req_write = ~wr;
    req_addr  = addr ^ 32'h0000_0004;
    req_wdata = ~wdata;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("resp_latency", lat, LAT + 1);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        chk("stall_valid", {31'd0, resp_valid}, 32'd1);
        chk("stall_rdata", resp_rdata, exp_rd);
        chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("idle_after_stall", {30'd0, req_ready, busy}, 32'd2);
    end else begin
      n = 0;
      while (busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("returns_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0000_0000);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);

    issue(1'b1, 32'h0000_0010, 32'h8000_00F1, 3'b010, 32'h0000_0000, 1'b0, 0); // SW
    issue(1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'h8000_00F1, 1'b0, 0); // LW
    issue(1'b1, 32'h0000_0012, 32'h0000_0055, 3'b000, 32'h0000_0000, 1'b0, 0); // SB
    issue(1'b0, 32'h0000_0012, 32'h0000_0000, 3'b100, 32'h0000_0055, 1'b0, 0); // LBU
    issue(1'b0, 32'h0000_0013, 32'h0000_0000, 3'b000, 32'hFFFF_FF80, 1'b0, 0); // LB
    issue(1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'h8055_00F1, 1'b0, 0); // LW
    issue(1'b0, 32'h0000_0010, 32'h0000_0000, 3'b001, 32'h0000_00F1, 1'b0, 0); // LH
    issue(1'b0, 32'h0000_0012, 32'h0000_0000, 3'b101, 32'h0000_8055, 1'b0, 0); // LHU
    issue(1'b0, 32'h0000_0012, 32'h0000_0000, 3'b001, 32'hFFFF_8055, 1'b0, 5); // LH, stalled

    // SW to 0x20 abandoned by rst on the edge that would perform the write.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h0000_0020;
    req_wdata  = 32'hDEAD_BEEF;
    req_funct3 = 3'b010;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    issue(1'b0, 32'h0000_0020, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b0, 0); // LW old data
    issue(1'b0, 32'h0000_1010, 32'h0000_0000, 3'b010, 32'h8055_00F1, 1'b0, 0); // wrap-around

    issue(1'b1, 32'h0000_0022, 32'h1234_BEEF, 3'b001, 32'h0000_0000, 1'b0, 0); // SH upper half
    issue(1'b0, 32'h0000_0020, 32'h0000_0000, 3'b010, 32'hBEEF_0000, 1'b0, 0);
    issue(1'b1, 32'h0000_0024, 32'hCAFE_F00D, 3'b011, 32'h0000_0000, 1'b0, 0); // unlisted -> SW
    issue(1'b0, 32'h0000_0024, 32'h0000_0000, 3'b010, 32'hCAFE_F00D, 1'b0, 0);
    issue(1'b0, 32'h0000_0025, 32'h0000_0000, 3'b100, 32'h0000_00F0, 1'b0, 0); // LBU byte 1
    issue(1'b0, 32'h0000_0027, 32'h0000_0000, 3'b000, 32'hFFFF_FFCA, 1'b0, 0); // LB byte 3

`ifdef MEM_RESPONDER_MISALIGN_CHK_EN
    issue(1'b0, 32'h0000_0011, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b1, 0); // LW misaligned
    issue(1'b0, 32'h0000_0011, 32'h0000_0000, 3'b001, 32'h0000_0000, 1'b1, 0); // LH misaligned
    issue(1'b1, 32'h0000_0011, 32'h1234_5678, 3'b010, 32'h0000_0000, 1'b1, 0); // SW misaligned
    issue(1'b0, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'h8055_00F1, 1'b0, 0); // unchanged
`else
    issue(1'b0, 32'h0000_0011, 32'h0000_0000, 3'b010, 32'h8055_00F1, 1'b0, 0); // force-aligned LW
    issue(1'b0, 32'h0000_0011, 32'h0000_0000, 3'b001, 32'h0000_00F1, 1'b0, 0); // force-aligned LH
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
